event_tx_arbiter: RTL and testbench

Arbitrates single-cycle event pulses from up to N sources, e.g. PPU new-frame, scanline compare and audio-buffer low, onto the synth's single external-transmit request/ack channel. Each source has a pending flag, an enable, a sticky overflow flag and a saturating miss counter. Pending events are granted round-robin and offered one at a time with a stable event code. The block sits at top level between the PPU/synth event producers and the synth's `ext_tx_request`/`ext_tx_ack` ports, replacing ad-hoc per-event pending logic.

---
 rtl/event_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_event_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_tx_arbiter.sv
// Round-robin arbiter that funnels single-cycle event pulses from N_SRC sources
// onto one request/ack transmit channel, tracking per-source overflow and losses.
module event_tx_arbiter #(
  parameter int N_SRC     = 4,
  parameter int CODE_BITS = 2,
  parameter int MISS_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_SRC-1:0]             src_pulse,
  input  logic [N_SRC-1:0]             src_en,
  output logic                         tx_request,
  output logic [CODE_BITS-1:0]         tx_code,
  input  logic                         tx_ack,
  output logic [N_SRC-1:0]             pending,
  output logic [N_SRC-1:0]             overflow,
  input  logic [N_SRC-1:0]             overflow_clr,
  output logic [N_SRC*MISS_BITS-1:0]   miss_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [MISS_BITS-1:0] MISS_MAX = {MISS_BITS{1'b1}};

  state_e                       state_q, state_d;
  logic [CODE_BITS-1:0]         rr_q, rr_d;
  logic [CODE_BITS-1:0]         tx_code_q, tx_code_d;
  logic                         tx_request_q, tx_request_d;
  logic [N_SRC-1:0]             pending_q, pending_d;
  logic [N_SRC-1:0]             overflow_q, overflow_d;
  logic [N_SRC*MISS_BITS-1:0]   miss_q, miss_d;

  logic                         ack_fire;
  logic [N_SRC-1:0]             src_acked;
  logic [N_SRC-1:0]             src_lost;

  function automatic logic [MISS_BITS-1:0] sat_inc(input logic [MISS_BITS-1:0] v);
    logic [MISS_BITS-1:0] r;
    if (v == MISS_MAX) begin
      r = v;
    end else begin
      r = v + MISS_BITS'(1);
    end
    return r;
  endfunction

  // First set request bit at or above start, wrapping around the source range.
  function automatic logic [CODE_BITS-1:0] rr_pick(input logic [N_SRC-1:0]     req,
                                                   input logic [CODE_BITS-1:0] start);
    logic                 found;
    logic [CODE_BITS-1:0] sel;
    int                   idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(start) + k) % N_SRC;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = CODE_BITS'(idx);
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  function automatic logic [CODE_BITS-1:0] next_idx(input logic [CODE_BITS-1:0] code);
    logic [CODE_BITS-1:0] r;
    if (code == CODE_BITS'(N_SRC - 1)) begin
      r = '0;
    end else begin
      r = code + CODE_BITS'(1);
    end
    return r;
  endfunction

  // Ack only counts while an offer is outstanding; it then targets the granted source.
  always_comb begin
    ack_fire  = (state_q == OFFER) && tx_ack;
    src_acked = '0;
    src_lost  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_acked[i] = ack_fire && (tx_code_q == CODE_BITS'(i));
      src_lost[i]  = src_en[i] && src_pulse[i] && pending_q[i] && !src_acked[i];
    end
  end

  // Per-source pending, overflow and miss counter next-state.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    miss_d     = miss_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (!src_en[i]) begin
        pending_d[i] = 1'b0;
      end else if (src_pulse[i]) begin
        pending_d[i] = 1'b1;
      end else if (src_acked[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end

      // A loss in the same cycle as a clear restarts the count at one.
      if (src_lost[i]) begin
        overflow_d[i] = 1'b1;
        if (overflow_clr[i]) begin
          miss_d[i*MISS_BITS +: MISS_BITS] = MISS_BITS'(1);
        end else begin
          miss_d[i*MISS_BITS +: MISS_BITS] = sat_inc(miss_q[i*MISS_BITS +: MISS_BITS]);
        end
      end else if (overflow_clr[i]) begin
        overflow_d[i]                    = 1'b0;
        miss_d[i*MISS_BITS +: MISS_BITS] = '0;
      end else begin
        overflow_d[i]                    = overflow_q[i];
        miss_d[i*MISS_BITS +: MISS_BITS] = miss_q[i*MISS_BITS +: MISS_BITS];
      end
    end
  end

  // Offer FSM: grant only in IDLE, hold the offer until ack, then one idle gap cycle.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    tx_code_d    = tx_code_q;
    tx_request_d = tx_request_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          tx_code_d    = rr_pick(pending_q, rr_q);
          tx_request_d = 1'b1;
          state_d      = OFFER;
        end else begin
          tx_request_d = 1'b0;
          state_d      = IDLE;
        end
      end
      OFFER: begin
        if (tx_ack) begin
          tx_request_d = 1'b0;
          rr_d         = next_idx(tx_code_q);
          state_d      = GAP;
        end else begin
          tx_request_d = 1'b1;
          state_d      = OFFER;
        end
      end
      GAP: begin
        tx_request_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        tx_request_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      tx_code_q    <= '0;
      tx_request_q <= 1'b0;
      pending_q    <= '0;
      overflow_q   <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      tx_code_q    <= tx_code_d;
      tx_request_q <= tx_request_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      miss_q       <= miss_d;
    end
  end

  assign tx_request = tx_request_q;
  assign tx_code    = tx_code_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_event_tx_arbiter.sv
// Directed self-checking bench for event_tx_arbiter with default parameters.
module tb_event_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_pulse;
  logic [3:0]  src_en;
  logic        tx_request;
  logic [1:0]  tx_code;
  logic        tx_ack;
  logic [3:0]  pending;
  logic [3:0]  overflow;
  logic [3:0]  overflow_clr;
  logic [15:0] miss_cnt;

  int tests;
  int fails;

  event_tx_arbiter #(.N_SRC(4), .CODE_BITS(2), .MISS_BITS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_pulse    (src_pulse),
    .src_en       (src_en),
    .tx_request   (tx_request),
    .tx_code      (tx_code),
    .tx_ack       (tx_ack),
    .pending      (pending),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .miss_cnt     (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle to the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    src_pulse    = 4'b0000;
    src_en       = 4'b1111;
    tx_ack       = 1'b0;
    overflow_clr = 4'b0000;

    // Reset
    tick();
    tick();
    chk("rst_req",  32'(tx_request), 32'd0);
    chk("rst_code", 32'(tx_code),    32'd0);
    chk("rst_pend", 32'(pending),    32'd0);
    chk("rst_ovf",  32'(overflow),   32'd0);
    chk("rst_miss", 32'(miss_cnt),   32'd0);
    rst_n = 1'b1;

    // Pulse on source 2: pending after one edge, request after two, held until ack
    src_pulse = 4'b0100;
    tick();
    src_pulse = 4'b0000;
    chk("p2_pend", 32'(pending),    32'h4);
    chk("p2_req0", 32'(tx_request), 32'd0);
    tick();
    chk("p2_req",  32'(tx_request), 32'd1);
    chk("p2_code", 32'(tx_code),    32'd2);
    tick();
    tick();
    chk("p2_hold_req",  32'(tx_request), 32'd1);
    chk("p2_hold_code", 32'(tx_code),    32'd2);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("p2_ack_req",  32'(tx_request), 32'd0);
    chk("p2_ack_pend", 32'(pending),    32'd0);
    tick();
    tick();

    // Round-robin from a fresh pointer: 0,1,2,3,0 with 3-cycle spacing
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    src_pulse = 4'b1111;
    tick();
    src_pulse = 4'b0000;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("rr_req",  32'(tx_request), 32'd1);
      chk("rr_code", 32'(tx_code),    32'(k % 4));
      tx_ack = 1'b1;
      if (k == 3) begin
        src_pulse = 4'b0001;
      end
      tick();
      tx_ack    = 1'b0;
      src_pulse = 4'b0000;
      chk("rr_gap1", 32'(tx_request), 32'd0);
      tick();
      chk("rr_gap2", 32'(tx_request), 32'd0);
      tick();
    end
    chk("rr_done_pend", 32'(pending), 32'd0);

    // Overflow on source 1 while its offer is stalled (pointer is 1)
    src_pulse = 4'b0010;
    tick();
    src_pulse = 4'b0000;
    tick();
    chk("ov_code", 32'(tx_code), 32'd1);
    src_pulse = 4'b0010;
    tick();
    src_pulse = 4'b0000;
    tick();
    src_pulse = 4'b0010;
    tick();
    src_pulse = 4'b0000;
    chk("ov_flag", 32'(overflow),       32'h2);
    chk("ov_miss", 32'(miss_cnt[7:4]),  32'd2);
    overflow_clr = 4'b0010;
    tick();
    overflow_clr = 4'b0000;
    chk("ov_clr_flag", 32'(overflow),      32'd0);
    chk("ov_clr_miss", 32'(miss_cnt[7:4]), 32'd0);
    src_pulse = 4'b0010;
    for (int n = 0; n < 20; n++) begin
      tick();
    end
    src_pulse = 4'b0000;
    chk("ov_sat_miss",  32'(miss_cnt[7:4]), 32'd15);
    chk("ov_sat_flag",  32'(overflow),      32'h2);
    chk("ov_stall_req", 32'(tx_request),    32'd1);
    chk("ov_others",    32'(miss_cnt & 16'hFF0F), 32'd0);
    src_pulse    = 4'b0010;
    overflow_clr = 4'b0010;
    tick();
    src_pulse    = 4'b0000;
    overflow_clr = 4'b0000;
    chk("ov_clrloss_flag", 32'(overflow),      32'h2);
    chk("ov_clrloss_miss", 32'(miss_cnt[7:4]), 32'd1);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("ov_ack_pend", 32'(pending),    32'd0);
    chk("ov_ack_req",  32'(tx_request), 32'd0);
    overflow_clr = 4'b0010;
    tick();
    overflow_clr = 4'b0000;
    chk("ov_final_flag", 32'(overflow), 32'd0);
    chk("ov_final_miss", 32'(miss_cnt), 32'd0);

    // Pulse coinciding with ack of granted source 0 (pointer is 2)
    src_pulse = 4'b0001;
    tick();
    src_pulse = 4'b0000;
    tick();
    chk("sa_code0", 32'(tx_code), 32'd0);
    src_pulse = 4'b0100;
    tick();
    tx_ack    = 1'b1;
    src_pulse = 4'b0001;
    tick();
    tx_ack    = 1'b0;
    src_pulse = 4'b0000;
    chk("sa_pend", 32'(pending),    32'h5);
    chk("sa_ovf",  32'(overflow),   32'd0);
    chk("sa_req",  32'(tx_request), 32'd0);
    tick();
    tick();
    chk("sa_next_code", 32'(tx_code), 32'd2);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick();
    tick();
    chk("sa_again_req",  32'(tx_request), 32'd1);
    chk("sa_again_code", 32'(tx_code),    32'd0);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick();
    tick();

    // Disable a pending but ungranted source 3 (pointer is 1)
    src_pulse = 4'b1010;
    tick();
    src_pulse = 4'b0000;
    tick();
    chk("dis_code", 32'(tx_code), 32'd1);
    src_en = 4'b0111;
    tick();
    chk("dis_pend", 32'(pending), 32'h2);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    src_en = 4'b1111;
    tick();
    tick();
    chk("dis_no_offer1", 32'(tx_request), 32'd0);
    tick();
    chk("dis_no_offer2", 32'(tx_request), 32'd0);

    // Disable source 3 while it is being offered: request is held (pointer is 2)
    src_pulse = 4'b1000;
    tick();
    src_pulse = 4'b0000;
    tick();
    chk("dg_code", 32'(tx_code), 32'd3);
    src_en = 4'b0111;
    tick();
    chk("dg_req",  32'(tx_request), 32'd1);
    chk("dg_code_hold", 32'(tx_code), 32'd3);
    chk("dg_pend", 32'(pending),    32'd0);
    tick();
    chk("dg_req2", 32'(tx_request), 32'd1);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    src_en = 4'b1111;
    chk("dg_ack_req", 32'(tx_request), 32'd0);
    tick();

    // Stray ack in IDLE (tx_code still 3, pointer is 0) and in GAP
    src_pulse = 4'b1110;
    tick();
    src_pulse = 4'b0000;
    tx_ack    = 1'b1;
    tick();
    tx_ack    = 1'b0;
    chk("st_idle_pend", 32'(pending),    32'hE);
    chk("st_idle_req",  32'(tx_request), 32'd1);
    chk("st_idle_code", 32'(tx_code),    32'd1);
    tx_ack = 1'b1;
    tick();
    tick();
    tx_ack = 1'b0;
    chk("st_gap_req",  32'(tx_request), 32'd0);
    chk("st_gap_pend", 32'(pending),    32'hC);
    tick();
    chk("st_next_req",  32'(tx_request), 32'd1);
    chk("st_next_code", 32'(tx_code),    32'd2);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick();
    tick();
    chk("st_last_code", 32'(tx_code), 32'd3);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    chk("st_end_pend", 32'(pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
